// File: rtl/soml_encoder.sv
// rtl/soml_encoder.sv - SOML space-time codeword generator, two column beats per symbol
// Symbol index selects x1/x2; columns are built from sign/select logic on the held symbol.
module soml_encoder #(
  parameter int                 FRAME_LEN = 8,
  parameter logic signed [15:0] AMP       = 16'sh0080
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_sym,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [63:0]                  out_col_r,
  output logic [63:0]                  out_col_i,
  output logic                         out_col,
  output logic                         out_last,
  output logic [$clog2(FRAME_LEN)-1:0] sym_cnt
);

  localparam int             CW       = $clog2(FRAME_LEN);
  localparam logic [CW-1:0]  LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [15:0]    POS      = AMP;
  localparam logic [15:0]    NEG      = -AMP;

  typedef enum logic [1:0] {IDLE, C0, C1} state_t;

  state_t     state, state_nxt;
  logic [3:0] sym_hold;
  logic       in_hs;

  function automatic logic [15:0] tern(input logic pos, input logic neg);
    if (pos)      return POS;
    else if (neg) return NEG;
    else          return 16'h0000;
  endfunction

  // Returns {real, imag}; column 1 lane2 is -conj(x2), lane3 is x1 unconjugated.
  function automatic logic [127:0] column(input logic [3:0] s, input logic col);
    logic x1_rp, x1_rn, x1_ip, x1_in;
    logic x2_rp, x2_rn, x2_ip, x2_in;
    logic [63:0] r, i;
    x1_rp = (s[3:2] == 2'd0);
    x1_rn = (s[3:2] == 2'd1);
    x1_ip = (s[3:2] == 2'd2);
    x1_in = (s[3:2] == 2'd3);
    x2_rp = (s[1:0] == 2'd2);
    x2_rn = (s[1:0] == 2'd0);
    x2_ip = (s[1:0] == 2'd1);
    x2_in = (s[1:0] == 2'd3);
    if (!col) begin
      r = {POS, NEG, tern(x1_rp, x1_rn), tern(x2_rp, x2_rn)};
      i = {32'h0, tern(x1_ip, x1_in), tern(x2_ip, x2_in)};
    end else begin
      r = {POS, POS, tern(x2_rn, x2_rp), tern(x1_rp, x1_rn)};
      i = {32'h0, tern(x2_ip, x2_in), tern(x1_ip, x1_in)};
    end
    return {r, i};
  endfunction

  assign in_hs = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_hs) state_nxt = C0;
      C0:      if (out_ready) state_nxt = C1;
      C1:      if (out_ready) state_nxt = in_valid ? C0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state != IDLE);
    out_col   = (state == C1);
    out_last  = (state == C1) && (sym_cnt == LAST_IDX);
    in_ready  = !rst && ((state == IDLE) || ((state == C1) && out_ready));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_hold  <= 4'h0;
      out_col_r <= 64'h0;
      out_col_i <= 64'h0;
      sym_cnt   <= '0;
    end else begin
      if (in_hs) begin
        sym_hold               <= in_sym;
        {out_col_r, out_col_i} <= column(in_sym, 1'b0);
      end else if (state == C0 && out_ready) begin
        {out_col_r, out_col_i} <= column(sym_hold, 1'b1);
      end
      if (state == C1 && out_ready)
        sym_cnt <= (sym_cnt == LAST_IDX) ? '0 : sym_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_soml_encoder.sv
// tb/tb_soml_encoder.sv - scoreboard bench for soml_encoder
// Expected beats come from a complex-valued model of the codeword, queued at input handshake.
module tb_soml_encoder;

  localparam int FRAME_LEN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_sym = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_col_r;
  logic [63:0] out_col_i;
  logic        out_col;
  logic        out_last;
  logic [2:0]  sym_cnt;

  soml_encoder #(.FRAME_LEN(FRAME_LEN), .AMP(16'sh0080)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .out_valid(out_valid), .out_ready(out_ready), .out_col_r(out_col_r),
    .out_col_i(out_col_i), .out_col(out_col), .out_last(out_last), .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic [63:0] i;
    logic        col;
    logic        last;
    logic [2:0]  cnt;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] log_r[$];
  logic [63:0] log_i[$];
  int          pop_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          model_cnt = 0;
  int          cyc = 0;
  bit          accepted = 1'b0;
  bit          held_valid = 1'b0;
  logic [63:0] held_r, held_i;
  logic        held_col;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] lane(input int v);
    return (v > 0) ? 16'h0080 : (v < 0) ? 16'hFF80 : 16'h0000;
  endfunction

  task automatic push_model(input logic [3:0] s);
    int x1r, x1i, x2r, x2i;
    beat_t b0, b1;
    case (s[3:2])
      2'd0: begin x1r = 1;  x1i = 0;  end
      2'd1: begin x1r = -1; x1i = 0;  end
      2'd2: begin x1r = 0;  x1i = 1;  end
      default: begin x1r = 0; x1i = -1; end
    endcase
    case (s[1:0])
      2'd0: begin x2r = -1; x2i = 0;  end
      2'd1: begin x2r = 0;  x2i = 1;  end
      2'd2: begin x2r = 1;  x2i = 0;  end
      default: begin x2r = 0; x2i = -1; end
    endcase
    b0.r = {lane(1), lane(-1), lane(x1r), lane(x2r)};
    b0.i = {lane(0), lane(0), lane(x1i), lane(x2i)};
    b0.col = 1'b0; b0.last = 1'b0; b0.cnt = 3'(model_cnt);
    b1.r = {lane(1), lane(1), lane(-x2r), lane(x1r)};
    b1.i = {lane(0), lane(0), lane(x2i), lane(x1i)};
    b1.col = 1'b1; b1.last = (model_cnt == FRAME_LEN - 1); b1.cnt = 3'(model_cnt);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    model_cnt = (model_cnt + 1) % FRAME_LEN;
  endtask

  task automatic cycle();
    beat_t e;
    @(negedge clk);
    cyc++;
    accepted = in_valid && in_ready;
    if (held_valid) begin
      chk("stall_r", out_col_r, held_r);
      chk("stall_i", out_col_i, held_i);
      chk("stall_col", 64'(out_col), 64'(held_col));
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    held_valid = out_valid && !out_ready;
    held_r = out_col_r; held_i = out_col_i; held_col = out_col;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("col_r", out_col_r, e.r);
        chk("col_i", out_col_i, e.i);
        chk("out_col", 64'(out_col), 64'(e.col));
        chk("out_last", 64'(out_last), 64'(e.last));
        chk("sym_cnt", 64'(sym_cnt), 64'(e.cnt));
        if (e.col) chk("in_ready_c1", 64'(in_ready), 64'd1);
      end
      log_r.push_back(out_col_r);
      log_i.push_back(out_col_i);
      pop_cyc.push_back(cyc);
    end
    if (accepted) push_model(in_sym);
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input int first, input bit rand_bp);
    int k = 0;
    int guard = 0;
    in_valid = 1'b1;
    in_sym = 4'(first);
    while (k < n && guard < 4000) begin
      if (rand_bp) out_ready = ($urandom_range(0, 1) == 1);
      cycle();
      guard++;
      if (accepted) begin
        k++;
        in_sym = 4'((first + 5 * k) % 16);
      end
    end
    in_valid = 1'b0;
    chk("stream_accepted", 64'(k), 64'(n));
  endtask

  task automatic drain(input bit rand_bp);
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 1000) begin
      if (rand_bp) out_ready = ($urandom_range(0, 1) == 1);
      cycle();
      guard++;
    end
    out_ready = 1'b1;
    chk("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic single(input logic [3:0] s, input logic [63:0] r0, input logic [63:0] i0,
                        input logic [63:0] r1, input logic [63:0] i1);
    log_r.delete(); log_i.delete();
    out_ready = 1'b1;
    stream(1, int'(s), 1'b0);
    drain(1'b0);
    chk("single_beats", 64'(log_r.size()), 64'd2);
    if (log_r.size() == 2) begin
      chk("single_r0", log_r[0], r0);
      chk("single_i0", log_i[0], i0);
      chk("single_r1", log_r[1], r1);
      chk("single_i1", log_i[1], i1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_r", out_col_r, 64'd0);
    chk("rst_i", out_col_i, 64'd0);
    chk("rst_cnt", 64'(sym_cnt), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    single(4'd0, 64'h0080FF800080FF80, 64'h0, 64'h0080008000800080, 64'h0);
    single(4'd9, 64'h0080FF8000000000, 64'h0000000000800080,
                 64'h0080008000000000, 64'h0000000000800080);
    single(4'd13, 64'h0080FF8000000000, 64'h00000000FF800080,
                  64'h0080008000000000, 64'h000000000080FF80);

    // 16 symbols back-to-back at full rate: 32 beats on consecutive cycles
    pop_cyc.delete();
    out_ready = 1'b1;
    stream(16, 0, 1'b0);
    drain(1'b0);
    chk("b2b_beats", 64'(pop_cyc.size()), 64'd32);
    if (pop_cyc.size() == 32) chk("b2b_span", 64'(pop_cyc[31] - pop_cyc[0]), 64'd31);

    stream(24, 3, 1'b1);
    drain(1'b1);

    // Reset while column 0 of Si=6 is stalled
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sym = 4'd6;
    cycle();
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_cnt_nonzero", 64'(sym_cnt != 0), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_r", out_col_r, 64'd0);
    chk("abort_i", out_col_i, 64'd0);
    chk("abort_cnt", 64'(sym_cnt), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    model_cnt = 0;
    held_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_release_in_ready", 64'(in_ready), 64'd1);
    single(4'd2, 64'h0080FF8000800080, 64'h0, 64'h00800080FF800080, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soml_encoder.md
# soml_encoder

Transmit-side space-time codeword generator for the SOML link. Accepts one 4-bit symbol index per handshake and streams the corresponding 4×2 complex codeword to the transmit datapath as two column beats: column 0 first, then column 1. Each column is four 16-bit lanes, real and imaginary, packed exactly as the SOML decoder's codeword table expects. A frame counter marks the last column of every FRAME_LEN-symbol frame.

## Interface
- FRAME_LEN, 8: symbols per frame; ≥2.
- AMP, 16'sh0080: unit amplitude (+1). −1 is encoded as the two's complement −AMP, which is 16'hFF80 at the default.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_sym is valid.
- in_ready  out  1  encoder can accept in_sym this cycle.
- in_sym  in  4  symbol index Si; [3:2] selects x1, [1:0] selects x2.
- out_valid  out  1  column beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_col_r  out  64  real lanes: lane0=[63:48], lane1=[47:32], lane2=[31:16], lane3=[15:0], signed Q8.7.
- out_col_i  out  64  imaginary lanes, same packing.
- out_col  out  1  column index of the current beat (0/1).
- out_last  out  1  beat is column 1 of symbol FRAME_LEN−1 of the frame.
- sym_cnt  out  $clog2(FRAME_LEN)  index within the frame of the symbol being output.

## Operation
- Symbol map:
  - x1 from Si[3:2]: 0→+1, 1→−1, 2→+j, 3→−j.
  - x2 from Si[1:0]: 0→−1, 1→+j, 2→+1, 3→−j.
- Codeword columns:
  - Column 0 lanes = (+1, −1, x1, x2).
  - Column 1 lanes = (+1, +1, −conj(x2), x1).
  - Column 1 lane3 is x1 itself, not conjugated. This is deliberate and matches the decoder table.
- Each lane value is ±AMP or 0 in both its real and imaginary parts. Imaginary lanes 0 and 1 are always 0.
- Output values are produced by sign/select logic from the decoded x1/x2, not by a lookup table.
- FSM:
  - IDLE: out_valid=0.
  - IDLE → C0 on an input handshake.
  - C0: column 0 registered, out_col=0. C0 → C1 on an output handshake.
  - C1: column 1, out_col=1.
    - On an output handshake: go to C0 if an input handshake occurs in the same cycle, otherwise go to IDLE.
    - While C1 is stalled, hold.
- in_ready = !rst && (state==IDLE || (state==C1 && out_ready)). This is a combinational path from out_ready; downstream must not make out_ready depend on in_ready.
- The input symbol is captured into a holding register on the handshake. Both columns are derived from the held value, so in_sym may change after acceptance.
- sym_cnt increments on a column-1 handshake and wraps FRAME_LEN−1 → 0.
- out_last = (state==C1 && sym_cnt==FRAME_LEN−1).
- While out_valid=1 and out_ready=0, all outputs are held stable. This is AXI-style: data never changes under valid.

## Timing
- Reset (asynchronous assert) sets:
  - state=IDLE, out_valid=0, out_col=0, out_last=0, sym_cnt=0.
  - out_col_r=0, out_col_i=0, holding register=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after deassertion.
- Latency: an input handshake at edge N gives column 0 with out_valid=1 after edge N. Column 1 appears the cycle after column 0's handshake.
- Throughput: one symbol per 2 cycles with out_ready held at 1. There are no bubbles between back-to-back symbols.
- Simultaneous column-1 output handshake and input handshake: the new symbol's column 0 is presented the next cycle.
- A stall in C0 or C1 holds in_ready=0, apart from the C1 && out_ready term.
- Reset mid-symbol (in C0 or C1) aborts the symbol: no column 1 is emitted and sym_cnt returns to 0.
- out_valid never drops between C0 and C1 of the same symbol unless reset is asserted.
- in_valid without in_ready has no effect. out_ready while idle has no effect.

## Test plan
- Si=0, out_ready=1:
  - column 0: r=0x0080FF800080FF80, i=0.
  - column 1: r=0x0080008000800080, i=0.
  - out_col sequence 0,1.
- Si=9:
  - column 0: r=0x0080FF8000000000, i=0x0000000000800080.
  - column 1: r=0x0080008000000000, i=0x0000000000800080.
- Si=13:
  - column 0: r=0x0080FF8000000000, i=0x00000000FF800080.
  - column 1: r=0x0080008000000000, i=0x000000000080FF80.
- All 16 Si values streamed back-to-back with out_ready=1:
  - 32 beats in 32 cycles, in_ready high on every C1 cycle.
  - out_last on beats 16 and 32 (FRAME_LEN=8).
  - sym_cnt wraps 7→0.
- Random out_ready backpressure (≈50%): output data and out_col stay stable while stalled; no symbols are lost or duplicated against a reference-model scoreboard.
- rst asserted in C0 with Si=6 pending: outputs go to 0 immediately; after release, a new Si=2 produces column 0 r=0x0080FF8000800080 with sym_cnt=0.
